// File: rtl/sb_slot_ctrl.sv
// Scoreboard slot scheduler: in-order trans_id allocation, multi-port writeback marking, in-order commit.
// Issue grant is same-cycle (stalled while full or flushing); writeback reaches commit_valid_o after one cycle.
module sb_slot_ctrl #(
  parameter  int NR_ENTRIES  = 4,
  parameter  int NR_WB_PORTS = 3,
  localparam int ID_BITS     = $clog2(NR_ENTRIES)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           issue_req_i,
  output logic                           issue_ack_o,
  output logic [ID_BITS-1:0]             issue_id_o,
  input  logic [NR_WB_PORTS-1:0]         wb_valid_i,
  input  logic [NR_WB_PORTS*ID_BITS-1:0] wb_id_i,
  output logic                           commit_valid_o,
  output logic [ID_BITS-1:0]             commit_id_o,
  input  logic                           commit_ack_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [ID_BITS:0]               count_o,
  output logic                           wb_err_o
);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_DONE} slot_state_e;

  slot_state_e           slot_q [NR_ENTRIES];
  logic [ID_BITS-1:0]    head_q;
  logic [ID_BITS-1:0]    tail_q;
  logic [ID_BITS:0]      count_q;
  logic                  wb_err_q;

  logic [ID_BITS-1:0]    wb_id [NR_WB_PORTS];
  logic [NR_ENTRIES-1:0] wb_done_mask;
  logic                  wb_err_d;
  logic                  commit_fire;

  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_id
    assign wb_id[p] = wb_id_i[p*ID_BITS +: ID_BITS];
  end

  // Full/empty come from the occupancy count, since head==tail is ambiguous.
  assign full_o         = (count_q == (ID_BITS+1)'(NR_ENTRIES));
  assign empty_o        = (count_q == '0);
  assign count_o        = count_q;
  assign issue_id_o     = tail_q;
  assign issue_ack_o    = issue_req_i & ~full_o & ~flush_i;
  assign commit_id_o    = head_q;
  assign commit_valid_o = ~empty_o & (slot_q[head_q] == SLOT_DONE);
  assign commit_fire    = commit_valid_o & commit_ack_i & ~flush_i;
  assign wb_err_o       = wb_err_q;

  // Duplicate ids across ports still complete an ISSUED slot once; only the error is raised.
  always_comb begin
    wb_done_mask = '0;
    wb_err_d     = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p]) begin
        if (slot_q[wb_id[p]] == SLOT_ISSUED) begin
          wb_done_mask[wb_id[p]] = 1'b1;
        end else begin
          wb_err_d = 1'b1;
        end
        for (int r = 0; r < p; r++) begin
          if (wb_valid_i[r] && (wb_id[r] == wb_id[p])) begin
            wb_err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        slot_q[i] <= SLOT_FREE;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (wb_done_mask[i]) begin
          slot_q[i] <= SLOT_DONE;
        end
      end
      if (issue_ack_o) begin
        slot_q[tail_q] <= SLOT_ISSUED;
        tail_q         <= tail_q + ID_BITS'(1);
      end
      if (commit_fire) begin
        slot_q[head_q] <= SLOT_FREE;
        head_q         <= head_q + ID_BITS'(1);
      end
      count_q <= count_q + (ID_BITS+1)'(issue_ack_o) - (ID_BITS+1)'(commit_fire);
    end
  end

endmodule

// File: tb/tb_sb_slot_ctrl.sv
// Bench for sb_slot_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sb_slot_ctrl;
  localparam int N  = 4;
  localparam int P  = 3;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          rst_n, flush, issue_req, issue_ack, commit_valid, commit_ack;
  logic          full, empty, wb_err;
  logic [IB-1:0] issue_id, commit_id;
  logic [P-1:0]  wb_valid;
  logic [P*IB-1:0] wb_id;
  logic [IB:0]   count;

  int n_chk  = 0;
  int n_fail = 0;
  bit en     = 0;

  // Reference model: outstanding ids oldest-first, completion flags, next id to hand out.
  int q[$];
  bit done_m [N];
  int next_id;
  bit err_m;

  sb_slot_ctrl #(.NR_ENTRIES(N), .NR_WB_PORTS(P)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_req_i(issue_req), .issue_ack_o(issue_ack), .issue_id_o(issue_id),
    .wb_valid_i(wb_valid), .wb_id_i(wb_id),
    .commit_valid_o(commit_valid), .commit_id_o(commit_id), .commit_ack_i(commit_ack),
    .full_o(full), .empty_o(empty), .count_o(count), .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  // Model update on each rising edge from the inputs held during the cycle.
  initial forever begin
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
      foreach (done_m[i]) done_m[i] = 1'b0;
      next_id = 0;
      err_m   = 1'b0;
    end else begin
      int ids [P];
      bit e;
      bit [N-1:0] mark;
      bit cv;
      bit ia;
      e    = 1'b0;
      mark = '0;
      ia   = issue_req && (q.size() < N);
      cv   = (q.size() > 0) && done_m[q[0]];
      for (int p = 0; p < P; p++) begin
        ids[p] = int'(wb_id[p*IB +: IB]);
        if (wb_valid[p]) begin
          if (!in_q(ids[p]) || done_m[ids[p]]) e = 1'b1;
          else mark[ids[p]] = 1'b1;
          for (int r = 0; r < p; r++)
            if (wb_valid[r] && ids[r] == ids[p]) e = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) if (mark[i]) done_m[i] = 1'b1;
      if (cv && commit_ack) begin
        done_m[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (ia) begin
        q.push_back(next_id);
        next_id = (next_id + 1) % N;
      end
      err_m = e;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (en) begin
      int sz;
      bit cv_e;
      int hd_e;
      sz   = q.size();
      cv_e = (sz > 0) ? done_m[q[0]] : 1'b0;
      hd_e = (sz > 0) ? q[0] : next_id;
      chk("m_count",   count,        sz);
      chk("m_full",    full,         sz == N);
      chk("m_empty",   empty,        sz == 0);
      chk("m_iss_ack", issue_ack,    issue_req && !flush && sz < N);
      chk("m_iss_id",  issue_id,     next_id);
      chk("m_cvalid",  commit_valid, cv_e);
      chk("m_cid",     commit_id,    hd_e);
      chk("m_wb_err",  wb_err,       err_m);
    end
  end

  task automatic idle();
    flush = 0; issue_req = 0; commit_ack = 0; wb_valid = '0; wb_id = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [P-1:0] v, input int a, input int b, input int c);
    wb_valid = v;
    wb_id    = {IB'(c), IB'(b), IB'(a)};
  endtask

  task automatic do_flush();
    idle(); flush = 1; step(); flush = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    en    = 1;
    #1;
    chk("rst_empty",  empty, 1);
    chk("rst_full",   full, 0);
    chk("rst_count",  count, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_cid",    commit_id, 0);
    chk("rst_iss_id", issue_id, 0);
    chk("rst_iss_ack", issue_ack, 0);
    chk("rst_wb_err", wb_err, 0);

    // Fill: four grants with ids 0..3, fifth request refused.
    issue_req = 1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      #1;
      if (k < 4) begin
        chk("fill_ack", issue_ack, 1);
        chk("fill_id",  issue_id, k);
      end else begin
        chk("fill_ack_full", issue_ack, 0);
        chk("fill_full",     full, 1);
        chk("fill_count",    count, 4);
      end
    end
    step();
    do_flush();

    // Out-of-order writeback, in-order commit.
    issue_req = 1; step(); step(); step(); issue_req = 0;
    commit_ack = 1;
    wb(3'b001, 2, 0, 0); step();
    wb(3'b001, 1, 0, 0); #1 chk("ooo_wait1", commit_valid, 0);
    step();
    wb(3'b001, 0, 0, 0); #1 chk("ooo_wait2", commit_valid, 0);
    step();
    wb(3'b000, 0, 0, 0); #1;
    chk("ooo_c0_v", commit_valid, 1); chk("ooo_c0_id", commit_id, 0);
    step(); #1;
    chk("ooo_c1_v", commit_valid, 1); chk("ooo_c1_id", commit_id, 1);
    step(); #1;
    chk("ooo_c2_v", commit_valid, 1); chk("ooo_c2_id", commit_id, 2);
    step(); #1;
    chk("ooo_empty", empty, 1);
    do_flush();

    // Parallel writeback on all ports.
    issue_req = 1; step(); step(); step(); step(); issue_req = 0;
    commit_ack = 1;
    wb(3'b111, 1, 0, 3); step();
    wb(3'b000, 0, 0, 0); #1;
    chk("par_c0_v", commit_valid, 1); chk("par_c0_id", commit_id, 0);
    step(); #1;
    chk("par_c1_id", commit_id, 1);
    step(); #1;
    chk("par_wait_v", commit_valid, 0); chk("par_wait_id", commit_id, 2);
    chk("par_count", count, 2); chk("par_err", wb_err, 0);
    wb(3'b001, 2, 0, 0); step();
    wb(3'b000, 0, 0, 0); #1;
    chk("par_c2_id", commit_id, 2);
    step(); step(); #1;
    chk("par_empty", empty, 1);
    do_flush();

    // Illegal writebacks: FREE slot, then duplicate id across ports.
    issue_req = 1; step(); issue_req = 0;
    wb(3'b001, 3, 0, 0); step();
    wb(3'b000, 0, 0, 0); #1 chk("ill_free_err", wb_err, 1);
    step(); #1 chk("ill_free_clr", wb_err, 0);
    wb(3'b011, 0, 0, 0); step();
    wb(3'b000, 0, 0, 0); #1;
    chk("ill_dup_err", wb_err, 1);
    chk("ill_dup_done", commit_valid, 1);
    chk("ill_dup_count", count, 1);
    step(); #1 chk("ill_dup_clr", wb_err, 0);
    do_flush();

    // Wrap-around with issue and commit every cycle.
    issue_req = 1; step(); step(); issue_req = 0;
    wb(3'b011, 0, 1, 0); step();
    for (int i = 0; i < 10; i++) begin
      issue_req = 1; commit_ack = 1;
      if (i > 0) wb(3'b001, (1 + i) % N, 0, 0);
      else wb(3'b000, 0, 0, 0);
      #1;
      chk("wrap_ack",   issue_ack, 1);
      chk("wrap_iid",   issue_id, (2 + i) % N);
      chk("wrap_cv",    commit_valid, 1);
      chk("wrap_cid",   commit_id, i % N);
      chk("wrap_count", count, 2);
      step();
    end
    do_flush();

    // Flush with outstanding entries, live issue and writebacks.
    issue_req = 1; step(); step(); step();
    flush = 1; wb(3'b111, 0, 1, 2); #1;
    chk("fl_ack", issue_ack, 0);
    step(); idle(); #1;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_iid",   issue_id, 0);
    chk("fl_err",   wb_err, 0);
    step(); #1 chk("fl_err2", wb_err, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_slot_ctrl.md
Name: sb_slot_ctrl

Overview:
Scheduler for the scoreboard entry pool. It allocates trans_ids in program order at issue, marks entries finished as functional units write back over NR_WB_PORTS ports, and presents the oldest finished entry for in-order commit. A flush returns every slot to free. It sits between the issue stage, the FU writeback buses and the commit stage.

Parameters:
NR_ENTRIES, 4, number of scoreboard slots; must be a power of 2 and at least 2; matches NR_SB_ENTRIES.
NR_WB_PORTS, 3, number of writeback ports; at least 1.
ID_BITS, $clog2(NR_ENTRIES), trans_id width; derived, not overridden.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  reset, synchronous, active-low.
flush_i  in  1  discard all outstanding entries.
issue_req_i  in  1  issue stage requests a slot.
issue_ack_o  out  1  slot granted this cycle.
issue_id_o  out  ID_BITS  trans_id of the granted slot (the tail pointer).
wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe.
wb_id_i  in  NR_WB_PORTS*ID_BITS  per-port trans_id; port p occupies bits [p*ID_BITS +: ID_BITS].
commit_valid_o  out  1  head entry is finished and may commit.
commit_id_o  out  ID_BITS  trans_id of the head entry.
commit_ack_i  in  1  commit stage retires the head entry.
full_o  out  1  count == NR_ENTRIES.
empty_o  out  1  count == 0.
count_o  out  ID_BITS+1  number of occupied slots.
wb_err_o  out  1  registered one-cycle pulse flagging an illegal writeback.

Behaviour:
- State
  - Per slot: FREE, ISSUED or DONE.
  - head and tail pointers, ID_BITS each; they wrap modulo NR_ENTRIES.
  - count, ID_BITS+1 bits.
- Reset (rst_ni=0 at a clock edge)
  - All slots FREE; head=0, tail=0, count=0, wb_err_o=0.
  - Resulting outputs: empty_o=1, full_o=0, commit_valid_o=0, commit_id_o=0, issue_id_o=0, issue_ack_o=0.
  - Reset mid-operation discards all state, the same as a flush.
- Issue
  - issue_ack_o = issue_req_i & ~full_o & ~flush_i. Combinational, no latency.
  - issue_id_o = tail at all times.
  - On ack: slot[tail] becomes ISSUED, tail increments, count increments.
  - A commit in the same cycle does not make room for issue when full. There is no bypass; full_o is from registered state.
- Writeback
  - For each port p with wb_valid_i[p]=1 whose slot is ISSUED: the slot becomes DONE at the next edge.
  - The following are illegal and assert wb_err_o in the next cycle:
    - the slot is FREE or already DONE;
    - two ports name the same id in one cycle.
  - An illegal writeback has no other side effect, except that duplicate ports still mark an ISSUED slot DONE once.
  - A writeback cannot complete an entry issued in the same cycle: the slot was FREE at sample time, so the writeback is illegal.
- Commit
  - commit_valid_o = ~empty_o & (slot[head]==DONE). commit_id_o = head. Both come from registered state only.
  - On commit_valid_o & commit_ack_i: slot[head] becomes FREE, head increments, count decrements.
  - commit_ack_i without commit_valid_o is ignored.
  - A writeback to the head slot becomes visible as commit_valid_o one cycle later (1-cycle writeback-to-commit latency).
- Simultaneous events
  - Issue and commit in one cycle: count unchanged, both pointers advance.
  - Issue, writebacks and commit all apply in the same cycle when they touch distinct slots.
- Flush
  - Priority: rst_ni over flush_i over all other inputs.
  - While flush_i=1: issue_ack_o=0, commit_ack_i is ignored, writebacks are ignored and produce no wb_err_o.
  - Next edge: all slots FREE, head=tail=0, count=0.
- Wrap-around
  - Pointers roll from NR_ENTRIES-1 to 0.
  - full versus empty is decided from count, never from pointer equality.

Test Plan:
- Reset then fill: hold issue_req_i=1 for 5 cycles -> issue_ack_o=1 with ids 0,1,2,3; 5th cycle ack=0, full_o=1, count_o=4.
- Out-of-order writeback, in-order commit: issue ids 0-2; write back id 2 then id 1, commit_ack_i=1 held -> commit_valid_o stays 0; write back id 0 -> next cycle commits 0,1,2 on consecutive cycles, then empty_o=1.
- Parallel writeback: ports 0,1,2 write ids 1,0,3 in one cycle with all issued -> all DONE; commits 0,1 follow; commit waits on id 2 -> wb_err_o=0 throughout.
- Illegal writebacks: write back a FREE id 3; then in one cycle ports 0 and 1 both write ISSUED id 0 -> wb_err_o pulses one cycle after each event; id 0 ends DONE, no other slot changes.
- Wrap plus simultaneous issue/commit: run 10 issue/writeback/commit cycles with issue and commit on the same cycle -> ids cycle 0,1,2,3,0,1; count_o stays constant.
- Flush with 3 outstanding entries, issue_req_i=1 and wb_valid_i=3'b111 on the flush cycle -> issue_ack_o=0, no wb_err_o; next cycle count_o=0, empty_o=1, issue_id_o=0.
